// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared constants and types for the instruction fetch unit.
//   PC_W_DEF / INSTR_W_DEF : default widths of program counter and instruction
//   HALT_INSTR             : encoding that parks the fetch unit (BR XZR)
//   NOP_INSTR              : all-zero word placed in the IF/ID register on flush
//   fetch_state_t          : FETCH / HALTED state encoding
package instr_fetch_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] HALT_INSTR = 32'hD600_03E0;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundle of the fetch unit's memory, control and IF/ID signals.
//   master : the fetch unit (drives imem_addr and the IF/ID outputs)
//   slave  : the surroundings (ROM, hazard/branch logic, decode stage)
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_valid;
    logic               halted;
    logic [31:0]        fetch_count;

    modport master (
        output imem_addr, if_instr, if_pc, if_valid, halted, fetch_count,
        input  imem_data, stall, br_taken, br_target
    );

    modport slave (
        input  imem_addr, if_instr, if_pc, if_valid, halted, fetch_count,
        output imem_data, stall, br_taken, br_target
    );
endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : squash - clear valid and replace instruction with NOP
//   load       : capture in_instr/in_pc as a valid instruction
//   drop       : clear valid only (instruction and pc hold)
//   (none)     : hold everything
//   if_instr, if_pc, if_valid : registered outputs
module if_id_reg
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               drop,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_instr <= '0;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else if (flush) begin
            if_instr <= INSTR_W'(NOP_INSTR);
            if_valid <= 1'b0;
        end else if (load) begin
            if_instr <= in_instr;
            if_pc    <= in_pc;
            if_valid <= 1'b1;
        end else if (drop) begin
            if_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, FETCH/HALTED state machine and fetch counter
// feeding an IF/ID register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_fetch_if.master (imem_addr/imem_data ROM port,
//              stall/br_taken/br_target controls, if_instr/if_pc/if_valid,
//              halted, fetch_count)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic clk,
    input  logic rst,
    instr_fetch_if.master bus
);
    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [31:0]     count_reg, count_next;
    logic            ifid_load, ifid_flush, ifid_drop;
    logic            is_halt;

    assign is_halt = (bus.imem_data == INSTR_W'(HALT_INSTR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            pc_reg    <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_drop  = 1'b0;
        unique case (state_reg)
            ST_FETCH: begin
                if (bus.br_taken) begin
                    // Redirect wins over a stall: the stalled instruction is on the wrong path.
                    pc_next    = bus.br_target;
                    ifid_flush = 1'b1;
                end else if (!bus.stall) begin
                    ifid_load  = 1'b1;
                    count_next = count_reg + 32'd1;
                    if (is_halt) begin
                        // The halt word itself is delivered; pc parks on it.
                        state_next = ST_HALTED;
                    end else begin
                        pc_next = pc_reg + PC_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (bus.br_taken) begin
                    // An older branch proves the halt was speculative.
                    pc_next    = bus.br_target;
                    ifid_flush = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    ifid_drop = 1'b1;
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (ifid_flush),
        .load     (ifid_load),
        .drop     (ifid_drop),
        .in_instr (bus.imem_data),
        .in_pc    (pc_reg),
        .if_instr (bus.if_instr),
        .if_pc    (bus.if_pc),
        .if_valid (bus.if_valid)
    );

    assign bus.imem_addr   = pc_reg;
    assign bus.halted      = (state_reg == ST_HALTED);
    assign bus.fetch_count = count_reg;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a behavioural reference
// model and literal pins at the key points of each scenario.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    instr_fetch_if #(.PC_W(16), .INSTR_W(32)) bus ();

    instr_fetch #(.PC_W(16), .INSTR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test program: 0..9 ordinary words, 0xA halts, everything else filler.
    function automatic logic [31:0] rom(input logic [15:0] a);
        if (a == 16'h000A)     return 32'hD600_03E0;
        else if (a < 16'h000A) return 32'h1100_0000 | {16'h0, a};
        else                   return 32'hEE00_0000 | {16'h0, a};
    endfunction

    assign bus.imem_data = rom(bus.imem_addr);

    // Reference model: what the fetch unit must hold after each edge.
    logic [15:0] m_pc, m_ifpc;
    logic [31:0] m_instr, m_count;
    logic        m_valid, m_halted;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 16'h0; m_ifpc <= 16'h0; m_instr <= 32'h0;
            m_count <= 32'h0; m_valid <= 1'b0; m_halted <= 1'b0;
        end else if (bus.br_taken) begin
            m_pc <= bus.br_target; m_valid <= 1'b0; m_instr <= 32'h0;
            m_halted <= 1'b0;
        end else if (m_halted) begin
            m_valid <= 1'b0;
        end else if (!bus.stall) begin
            m_instr <= rom(m_pc);
            m_ifpc  <= m_pc;
            m_valid <= 1'b1;
            m_count <= m_count + 32'd1;
            if (rom(m_pc) == 32'hD600_03E0) m_halted <= 1'b1;
            else                            m_pc <= m_pc + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("imem_addr", {16'h0, bus.imem_addr}, {16'h0, m_pc});
        chk("halted", {31'h0, bus.halted}, {31'h0, m_halted});
        chk("if_valid", {31'h0, bus.if_valid}, {31'h0, m_valid});
        chk("fetch_count", bus.fetch_count, m_count);
        if (m_valid) begin
            chk("if_instr", bus.if_instr, m_instr);
            chk("if_pc", {16'h0, bus.if_pc}, {16'h0, m_ifpc});
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            compare_all();
            $display("t=%0t pc=%h if_pc=%h if_instr=%h v=%0d h=%0d cnt=%0d",
                     $time, bus.imem_addr, bus.if_pc, bus.if_instr,
                     bus.if_valid, bus.halted, bus.fetch_count);
        end
    endtask

    logic [31:0] cnt_snap;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = 16'h0;
        #3;
        chk("rst_pc", {16'h0, bus.imem_addr}, 32'h0);
        chk("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_count", bus.fetch_count, 32'h0);
        chk("rst_halted", {31'h0, bus.halted}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free run to the halt word at 0x000A.
        step(1);
        chk("first_fetch_pc", {16'h0, bus.if_pc}, 32'h0);
        chk("first_fetch_instr", bus.if_instr, 32'h1100_0000);
        step(10);
        chk("halt_halted", {31'h0, bus.halted}, 32'h1);
        chk("halt_instr", bus.if_instr, 32'hD600_03E0);
        chk("halt_ifpc", {16'h0, bus.if_pc}, 32'h0000_000A);
        chk("halt_count", bus.fetch_count, 32'd11);
        chk("halt_pc", {16'h0, bus.imem_addr}, 32'h0000_000A);
        bus.stall = 1'b1;
        step(2);
        bus.stall = 1'b0;
        chk("halted_bubble", {31'h0, bus.if_valid}, 32'h0);
        chk("halted_count", bus.fetch_count, 32'd11);

        // Branch out of HALTED to 0x0002.
        bus.br_taken = 1'b1; bus.br_target = 16'h0002;
        step(1);
        bus.br_taken = 1'b0;
        chk("unhalt_halted", {31'h0, bus.halted}, 32'h0);
        chk("unhalt_pc", {16'h0, bus.imem_addr}, 32'h2);
        step(1);
        chk("unhalt_fetch", {16'h0, bus.if_pc}, 32'h2);

        // Stall for three cycles with pc=0x0003.
        cnt_snap = bus.fetch_count;
        chk("pre_stall_count", cnt_snap, 32'd12);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_pc", {16'h0, bus.imem_addr}, 32'h3);
            chk("stall_count", bus.fetch_count, 32'd12);
            chk("stall_ifpc", {16'h0, bus.if_pc}, 32'h2);
        end
        bus.stall = 1'b0;
        step(1);
        chk("post_stall_ifpc", {16'h0, bus.if_pc}, 32'h3);
        chk("post_stall_instr", bus.if_instr, 32'h1100_0003);

        // Branch and stall together at pc=0x0005: branch wins.
        step(1);
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 16'h0000;
        step(1);
        bus.stall = 1'b0; bus.br_taken = 1'b0;
        chk("brstall_pc", {16'h0, bus.imem_addr}, 32'h0);
        chk("brstall_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("brstall_instr", bus.if_instr, 32'h0);

        // Branch back from pc=0x0009 to 0x0004.
        step(9);
        chk("at_nine", {16'h0, bus.imem_addr}, 32'h9);
        bus.br_taken = 1'b1; bus.br_target = 16'h0004;
        step(1);
        bus.br_taken = 1'b0;
        chk("br_pc", {16'h0, bus.imem_addr}, 32'h4);
        chk("br_bubble", {31'h0, bus.if_valid}, 32'h0);
        step(1);
        chk("br_resume", {16'h0, bus.if_pc}, 32'h4);

        // pc wrap from 0xFFFF.
        bus.br_taken = 1'b1; bus.br_target = 16'hFFFF;
        step(1);
        bus.br_taken = 1'b0;
        step(1);
        chk("wrap_pc", {16'h0, bus.imem_addr}, 32'h0);
        chk("wrap_ifpc", {16'h0, bus.if_pc}, 32'h0000_FFFF);

        // Run to halt again, then reset asynchronously between edges.
        step(11);
        chk("halt2", {31'h0, bus.halted}, 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", {16'h0, bus.imem_addr}, 32'h0);
        chk("arst_halted", {31'h0, bus.halted}, 32'h0);
        chk("arst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("arst_instr", bus.if_instr, 32'h0);
        chk("arst_ifpc", {16'h0, bus.if_pc}, 32'h0);
        chk("arst_count", bus.fetch_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("restart_ifpc", {16'h0, bus.if_pc}, 32'h0);
        chk("restart_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("restart_pc", {16'h0, bus.imem_addr}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 16, width of program counter and instruction-memory address (word-indexed).
REQ-002 Parameter INSTR_W, default 32, width of an instruction word.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  PC_W  word address to combinational instruction ROM; equals current pc.
REQ-006 imem_data  input  INSTR_W  instruction returned by ROM for imem_addr, same cycle.
REQ-007 stall  input  1  downstream hazard; hold pc and fetch register.
REQ-008 br_taken  input  1  downstream stage resolved a taken branch this cycle.
REQ-009 br_target  input  PC_W  word address to redirect to when br_taken=1.
REQ-010 if_instr  output  INSTR_W  registered fetched instruction (IF/ID).
REQ-011 if_pc  output  PC_W  registered address of if_instr.
REQ-012 if_valid  output  1  if_instr/if_pc hold a real instruction.
REQ-013 halted  output  1  fetch unit is in HALTED state.
REQ-014 fetch_count  output  32  number of instructions latched with if_valid=1 since reset.

Function
REQ-015 imem_addr SHALL equal pc combinationally at all times.
REQ-016 State machine SHALL have two states: FETCH and HALTED.
REQ-017 Priority per cycle, in FETCH: br_taken > stall > normal fetch.
REQ-018 FETCH, br_taken=1: pc<=br_target, if_valid<=0, if_instr<=0, stall ignored, state stays FETCH.
REQ-019 FETCH, stall=1, br_taken=0: pc, if_instr, if_pc, if_valid, fetch_count SHALL hold.
REQ-020 FETCH, normal: if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+1, fetch_count<=fetch_count+1.
REQ-021 pc increment SHALL wrap modulo 2^PC_W (0xFFFF+1 -> 0x0000); fetch_count SHALL wrap modulo 2^32.
REQ-022 Normal fetch with imem_data == HALT_INSTR (0xD60003E0, BR XZR): latch as REQ-020 except pc SHALL hold; state -> HALTED.
REQ-023 HALTED, br_taken=0: pc holds, if_valid<=0, fetch_count holds; stall has no effect.
REQ-024 HALTED, br_taken=1 (older branch squashes wrong-path halt): pc<=br_target, if_valid<=0, state -> FETCH.
REQ-025 halted SHALL be 1 exactly when state is HALTED.
REQ-026 Fetch latency: instruction at address A SHALL appear on if_instr one rising edge after pc==A with stall=0, br_taken=0.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force pc=0, if_instr=0, if_pc=0, if_valid=0, fetch_count=0, state=FETCH, halted=0.
REQ-028 Reset asserted mid-stall, mid-branch or in HALTED SHALL take precedence over all other inputs.
REQ-029 First fetch after reset release SHALL be from address 0 on the first rising edge with reset=0.

Structure
REQ-030 Shared package SHALL hold PC_W, INSTR_W defaults, HALT_INSTR constant, NOP/zero-instruction constant and the FETCH/HALTED state encoding.
REQ-031 The IF/ID register (if_instr, if_pc, if_valid with hold/flush controls) SHALL be one sub-module named if_id_reg; pc, FSM and counter stay in instr_fetch.

Verification
REQ-032 Reset, then free-run with ROM test program (halt at addr 0x000A) -> imem_addr 0,1,2,...,A; if_pc follows one cycle later; halted=1 after latching 0xD60003E0 at if_pc=0x000A; fetch_count=11.
REQ-033 At pc=0x0009, pulse br_taken with br_target=0x0004 -> next pc=0x0004, one bubble (if_valid=0), fetch resumes at 0x0004.
REQ-034 stall=1 for 3 cycles at pc=0x0003 -> pc, if_instr, if_pc, fetch_count unchanged for 3 cycles; then 0x0003 fetched normally.
REQ-035 br_taken and stall both 1 at pc=0x0005, br_target=0x0000 -> pc=0x0000, if_valid=0 (branch wins).
REQ-036 In HALTED, br_taken=1, br_target=0x0002 -> halted drops, fetch resumes at 0x0002; separately, preload pc=0xFFFF via br_target -> next pc=0x0000.
REQ-037 Assert reset asynchronously between clock edges while HALTED -> all outputs zero before next edge; fetch restarts at 0x0000.
